// File: rtl/prefetch_queue_if.sv
// -----------------------------------------------------------------------------
// prefetch_queue_if
// Bundles the fetch front end's three handshakes: the I-cache
// request/response pair, the redirect from branch/jump logic and the
// instruction stream towards decode.
//   master : the prefetch queue (drives icReq*, instr*, count)
//   slave  : the environment (I-cache, branch unit, decode)
// -----------------------------------------------------------------------------
interface prefetch_queue_if #(
   parameter int XLEN  = 32,
   parameter int IW    = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic            icReqValid;
   logic            icReqReady;
   logic [XLEN-1:0] icReqAddr;
   logic            icRspValid;
   logic [IW-1:0]   icRspData;
   logic            redirectValid;
   logic [XLEN-1:0] redirectPc;
   logic            instrValid;
   logic [IW-1:0]   instrData;
   logic [XLEN-1:0] instrPc;
   logic            instrReady;
   logic [CW-1:0]   count;

   modport master (
      output icReqValid, icReqAddr, instrValid, instrData, instrPc, count,
      input  icReqReady, icRspValid, icRspData, redirectValid, redirectPc,
             instrReady
   );

   modport slave (
      input  icReqValid, icReqAddr, instrValid, instrData, instrPc, count,
      output icReqReady, icRspValid, icRspData, redirectValid, redirectPc,
             instrReady
   );
endinterface

// File: rtl/prefetch_queue.sv
// -----------------------------------------------------------------------------
// prefetch_queue
// Instruction-fetch front end: PC generator, variable-latency I-cache
// handshake (in-order responses, up to MAX_OUT outstanding) and a DEPTH-entry
// in-order buffer feeding decode. A redirect flushes the buffer and turns
// every outstanding I-cache response into a drop.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : prefetch_queue_if.master (I-cache req/rsp, redirect, decode, count)
// -----------------------------------------------------------------------------
module prefetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              IW       = 32,
   parameter int              DEPTH    = 4,
   parameter int              MAX_OUT  = 2,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic               clk,
   input logic               rst,
   prefetch_queue_if.master  bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int SW = ((CW > OW) ? CW : OW) + 1;
   localparam logic [OW-1:0] MAX_OUT_W = OW'(MAX_OUT);
   localparam logic [SW-1:0] DEPTH_S   = SW'(DEPTH);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] tail_pc_q, tail_pc_d;
   logic [OW-1:0]   inflight_q, inflight_d;
   logic [OW-1:0]   drop_q, drop_d;
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;

   logic [XLEN-1:0] pc_mem_q   [DEPTH];
   logic [IW-1:0]   data_mem_q [DEPTH];

   logic            redirect;
   logic            rsp_ok;
   logic            req_valid;
   logic            req_fire;
   logic            push;
   logic            pop;
   logic [OW-1:0]   live;
   logic [SW-1:0]   occ;
   logic [XLEN-1:0] redir_pc;

   assign redirect = bus.redirectValid;
   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp_ok   = bus.icRspValid && (inflight_q != '0);
   assign live     = inflight_q - drop_q;
   // Credit: buffered entries plus live responses never exceed DEPTH, so
   // every live response is guaranteed a free slot when it returns.
   assign occ      = SW'(count_q) + SW'(live);
   // rst gating keeps icReqValid low while reset is held.
   assign req_valid = rst && !redirect && (inflight_q < MAX_OUT_W) && (occ < DEPTH_S);
   assign req_fire  = req_valid && bus.icReqReady;
   assign push      = rsp_ok && !redirect && (drop_q == '0);
   assign pop       = (count_q != '0) && bus.instrReady && !redirect;
   assign redir_pc  = bus.redirectPc & ~XLEN'(3);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      tail_pc_d  = tail_pc_q;
      drop_d     = drop_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      // req_fire is already suppressed in a redirect cycle
      inflight_d = inflight_q + OW'(req_fire) - OW'(rsp_ok);
      if (redirect) begin
         fetch_pc_d = redir_pc;
         tail_pc_d  = redir_pc;
         count_d    = '0;
         head_d     = tail_q;
         // everything still outstanding after this cycle is squashed
         drop_d     = inflight_q - OW'(rsp_ok);
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (rsp_ok && (drop_q != '0)) drop_d = drop_q - OW'(1);
         if (push) begin
            tail_d    = tail_q + PW'(1);
            tail_pc_d = tail_pc_q + XLEN'(4);
         end
         if (pop) head_d = head_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         tail_pc_q  <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         tail_pc_q  <= tail_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: contents are only observed when count != 0.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[tail_q]   <= tail_pc_q;
         data_mem_q[tail_q] <= bus.icRspData;
      end
   end

   assign bus.icReqValid = req_valid;
   assign bus.icReqAddr  = fetch_pc_q;
   assign bus.instrValid = (count_q != '0);
   assign bus.instrData  = data_mem_q[head_q];
   assign bus.instrPc    = pc_mem_q[head_q];
   assign bus.count      = count_q;
endmodule

// File: tb/tb_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_prefetch_queue
// Drives prefetch_queue with randomized I-cache / redirect / decode traffic.
// The reference model works per "fetch epoch": after reset or redirect the
// expected stream is the aligned start PC, +4, +8 ... and only responses to
// requests accepted in the current epoch contribute. A monitor compares the
// DUT against that model every cycle.
// -----------------------------------------------------------------------------
module tb_prefetch_queue;
   localparam int          XLEN     = 32;
   localparam int          IW       = 32;
   localparam int          DEPTH    = 4;
   localparam int          MAX_OUT  = 2;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   prefetch_queue_if #(.XLEN(XLEN), .IW(IW), .DEPTH(DEPTH)) bus ();

   prefetch_queue #(
      .XLEN(XLEN), .IW(IW), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {logic [31:0] addr; int epoch; int due;} req_t;
   typedef struct {logic [31:0] pc; logic [31:0] data;} exp_t;

   req_t cq[$];   // I-cache model: accepted requests awaiting response
   exp_t sb[$];   // scoreboard: instructions decode must receive, in order

   int n_pass = 0, n_total = 0, n_pops = 0, cyc = 0;
   int epoch = 0, rsp_epoch = -1, lat_max = 1;
   int m_inflight = 0, m_live = 0;
   logic [31:0] m_fetch = RESET_PC, m_tail = RESET_PC;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] idata(input logic [31:0] a);
      return a ^ 32'hC3C3_5A5A;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
   endtask

   // Monitor / reference model, evaluated mid-cycle once inputs are settled.
   initial begin
      exp_t e;
      logic exp_req;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("rst_reqvalid", bus.icReqValid, 0);
            chk("rst_instrvalid", bus.instrValid, 0);
            chk("rst_count", bus.count, 0);
            chk("rst_reqaddr", bus.icReqAddr, RESET_PC);
            sb.delete();
            m_inflight = 0; m_live = 0;
            m_fetch = RESET_PC; m_tail = RESET_PC;
            epoch++;
         end else begin
            exp_req = !bus.redirectValid && (m_inflight < MAX_OUT) &&
                      (sb.size() + m_live < DEPTH);
            chk("req_valid", bus.icReqValid, exp_req);
            chk("count", bus.count, sb.size());
            chk("instr_valid", bus.instrValid, sb.size() != 0);
            if (bus.redirectValid) begin
               if (bus.icRspValid && rsp_epoch >= 0) m_inflight--;
               sb.delete();
               m_live = 0;
               epoch++;
               m_fetch = bus.redirectPc & ~32'h3;
               m_tail  = m_fetch;
            end else begin
               if (bus.instrValid && bus.instrReady) begin
                  if (sb.size() == 0) chk("pop_expected", 0, 1);
                  else begin
                     e = sb.pop_front();
                     chk("instr_pc", bus.instrPc, e.pc);
                     chk("instr_data", bus.instrData, e.data);
                     n_pops++;
                  end
               end
               if (bus.icReqValid && bus.icReqReady) begin
                  chk("req_addr", bus.icReqAddr, m_fetch);
                  cq.push_back('{m_fetch, epoch, cyc + $urandom_range(lat_max, 1)});
                  m_fetch += 4;
                  m_inflight++;
                  m_live++;
               end
               if (bus.icRspValid && rsp_epoch >= 0) begin
                  m_inflight--;
                  if (rsp_epoch == epoch) begin
                     m_live--;
                     sb.push_back('{m_tail, idata(m_tail)});
                     m_tail += 4;
                  end
               end
            end
         end
      end
   end

   // One cycle of stimulus; I-cache answers the oldest request once due.
   task automatic drive(input int rdy, input int irdy, input int rpct,
                        input bit force_r, input logic [31:0] fpc);
      req_t r;
      @(posedge clk); #1;
      bus.icReqReady    = ($urandom_range(99) < rdy);
      bus.instrReady    = ($urandom_range(99) < irdy);
      bus.redirectValid = force_r || ($urandom_range(99) < rpct);
      bus.redirectPc    = force_r ? fpc : $urandom;
      bus.icRspValid    = 1'b0;
      bus.icRspData     = $urandom;
      rsp_epoch         = -1;
      if (cq.size() != 0 && cq[0].due <= cyc) begin
         r = cq.pop_front();
         bus.icRspValid = 1'b1;
         bus.icRspData  = idata(r.addr);
         rsp_epoch      = r.epoch;
      end else if (cq.size() == 0 && $urandom_range(99) < 3) begin
         bus.icRspValid = 1'b1;   // stray pulse with nothing outstanding
      end
   endtask

   initial begin
      bus.icReqReady = 0; bus.instrReady = 0; bus.icRspValid = 0;
      bus.icRspData = 0; bus.redirectValid = 0; bus.redirectPc = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1 chk("first_req", bus.icReqValid, 1);

      lat_max = 1;
      repeat (40) drive(100, 100, 0, 0, 0);       // streaming
      repeat (10) drive(100, 0, 0, 0, 0);         // decode stalled
      repeat (10) drive(100, 100, 0, 0, 0);
      lat_max = 3;
      repeat (6)  drive(100, 100, 0, 0, 0);
      drive(100, 100, 0, 1, 32'h0000_0103);       // squash in-flight
      repeat (15) drive(100, 100, 0, 0, 0);
      repeat (5)  drive(0, 100, 0, 0, 0);         // I-cache stalled
      lat_max = 1;
      drive(100, 100, 0, 1, 32'hFFFF_FFF5);       // PC wraps past 0
      repeat (12) drive(100, 100, 0, 0, 0);
      for (int s = 0; s < 15; s++) begin
         lat_max = $urandom_range(4, 1);
         repeat (100) drive(70, 60, 3, 0, 0);
      end

      // asynchronous reset mid-stream
      lat_max = 3;
      repeat (4) drive(100, 100, 0, 0, 0);
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      chk("async_rst_reqvalid", bus.icReqValid, 0);
      chk("async_rst_instrvalid", bus.instrValid, 0);
      chk("async_rst_count", bus.count, 0);
      chk("async_rst_reqaddr", bus.icReqAddr, RESET_PC);
      cq.delete();
      bus.icRspValid = 0; bus.redirectValid = 0; bus.icReqReady = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) begin                            // leftover responses after release
         @(posedge clk); #1;
         bus.icReqReady = 0; bus.icRspValid = 1; rsp_epoch = -1;
         bus.icRspData = $urandom;
      end
      for (int s = 0; s < 3; s++) begin
         lat_max = $urandom_range(4, 1);
         repeat (100) drive(80, 70, 2, 0, 0);
      end

      lat_max = 1;
      repeat (20) drive(0, 100, 0, 0, 0);         // drain
      @(posedge clk); #1;
      bus.icRspValid = 0; bus.redirectValid = 0;
      @(negedge clk);
      chk("pops_seen", n_pops > 200, 1);
      chk("drained_count", bus.count, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
